// File: rtl/usart_tx_fifo.sv
// usart_tx_fifo
//  UART transmitter with a small input FIFO. Words enter through a
//  valid/ready handshake, wait in the FIFO and go out as frames:
//  start bit (0), DATA_BITS data bits LSB first, optional parity bit, then
//  STOP_BITS stop bits (1). The line idles high. When a word is waiting at
//  the end of a frame, the next frame starts with no idle gap.
//
//  Optional feature: define USART_TX_PARITY_EN to add the parity_odd input
//  and a parity bit after the data bits (even parity when parity_odd=0).
//
//  Handshake: a word is taken on a rising edge where tx_valid && tx_ready.
//  tx_ready is high whenever the FIFO is not full and does not depend on
//  tx_valid. A word offered while tx_ready is low is dropped.
//
//  Ports
//   clock        system clock, rising edge
//   reset        synchronous, active-low; aborts any frame, flushes the FIFO
//   prescaler    bit period = prescaler+1 clocks, latched at frame start
//   tx_data      word to send
//   tx_valid     tx_data valid this cycle
//   parity_odd   (USART_TX_PARITY_EN only) odd parity select, latched at frame start
//   tx_ready     FIFO can accept a word
//   tx_pin       serial line (registered)
//   busy         high from start bit through the last stop clock
//   frame_done   1-cycle pulse in the last clock of the final stop bit
//   fifo_count   words currently queued
//   debug_state  current FSM state encoding
module usart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PRESC_W    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [PRESC_W-1:0]          prescaler,
    input  logic [DATA_BITS-1:0]        tx_data,
    input  logic                        tx_valid,
`ifdef USART_TX_PARITY_EN
    input  logic                        parity_odd,
`endif
    output logic                        tx_ready,
    output logic                        tx_pin,
    output logic                        busy,
    output logic                        frame_done,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic [2:0]                  debug_state
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PRESC_W-1:0] BAUD_ONE = PRESC_W'(1);
    localparam logic [3:0]       LAST_BIT  = 4'(DATA_BITS - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3
`ifdef USART_TX_PARITY_EN
        ,
        S_PARITY = 3'd4
`endif
    } state_t;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W:0]       count_q;
    logic                 push;
    logic                 pop;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] head;

    assign tx_ready   = (count_q != FULL_CNT);
    assign push       = tx_valid && tx_ready;
    assign fifo_empty = (count_q == '0);
    assign head       = mem[rd_ptr];
    assign fifo_count = count_q;

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !pop)      count_q <= count_q + CNT_ONE;
            else if (pop && !push) count_q <= count_q - CNT_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [PRESC_W-1:0]   presc_q, presc_d;
    logic [PRESC_W-1:0]   baud_q, baud_d;
    logic [3:0]           bit_q, bit_d;
    logic                 stop_q, stop_d;
    logic                 tx_q, line_d;
    logic                 tick;
    logic                 done;
`ifdef USART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    assign tick = (baud_q == presc_q);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            shift_q  <= '0;
            presc_q  <= '0;
            baud_q   <= '0;
            bit_q    <= '0;
            stop_q   <= 1'b0;
            tx_q     <= 1'b1;
`ifdef USART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            presc_q  <= presc_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            stop_q   <= stop_d;
            tx_q     <= line_d;
`ifdef USART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        presc_d  = presc_q;
        baud_d   = tick ? '0 : baud_q + BAUD_ONE;
        bit_d    = bit_q;
        stop_d   = stop_q;
        pop      = 1'b0;
        done     = 1'b0;
        line_d   = 1'b1;
`ifdef USART_TX_PARITY_EN
        parity_d = parity_q;
`endif

        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    state_d  = S_START;
                    shift_d  = head;
                    presc_d  = prescaler;
`ifdef USART_TX_PARITY_EN
                    parity_d = (^head) ^ parity_odd;
`endif
                end
            end
            S_START: begin
                if (tick) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == LAST_BIT) begin
`ifdef USART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                        stop_d  = 1'b0;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
`ifdef USART_TX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    state_d = S_STOP;
                    stop_d  = 1'b0;
                end
            end
`endif
            S_STOP: begin
                if (tick) begin
                    if (stop_q == LAST_STOP) begin
                        done = 1'b1;
                        // Chain straight into the next frame when a word waits.
                        if (!fifo_empty) begin
                            pop      = 1'b1;
                            state_d  = S_START;
                            shift_d  = head;
                            presc_d  = prescaler;
                            baud_d   = '0;
`ifdef USART_TX_PARITY_EN
                            parity_d = (^head) ^ parity_odd;
`endif
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Registered line: value for the state being entered at this edge.
        case (state_d)
            S_START:  line_d = 1'b0;
            S_DATA:   line_d = shift_d[0];
`ifdef USART_TX_PARITY_EN
            S_PARITY: line_d = parity_d;
`endif
            default:  line_d = 1'b1;
        endcase
    end

    assign tx_pin      = tx_q;
    assign busy        = (state_q != S_IDLE);
    assign frame_done  = done;
    assign debug_state = state_q;

endmodule
